uart_tx_mmio: RTL
=================

// Module: uart_tx_mmio
// PURPOSE
//  Memory-mapped UART transmitter on the core data bus, alongside the data memory.
//  It decodes its own two-word window: the memory write port with the data memory's
//  bus signals (bdi, baddr, bwr, bsz) and a combinational bdo.
//  Byte writes to DATA go into a TX FIFO and are serialised as 8N1 on tx.
//  It replaces simulation-only character printing with synthesisable output.
// PARAMETERS
//  BASE          32'h80000000  byte address of DATA; STATUS is at BASE+4
//  CLKS_PER_BIT  16            clk cycles per serial bit, >=2
//  LOG_DEPTH     3             FIFO depth = 2**LOG_DEPTH entries of 8 bits
// PORTS
//  clk    in   1   clock; all state on posedge
//  rst_n  in   1   asynchronous active-low reset
//  bdi    in   32  write data; only bdi[7:0] is used
//  baddr  in   32  byte address; decoded on baddr[31:2]
//  bwr    in   1   write strobe, one access per cycle
//  bsz    in   2   access size; ignored (any size accepted)
//  bdo    out  32  read data, combinational; 0 when baddr is outside the window
//  tx     out  1   serial output, idle high
//  irq    out  1   high while FIFO empty and FSM IDLE (tx_done level)
// BEHAVIOUR
//  Reset (async, immediate): tx=1, FIFO empty (rd/wr ptr=0), FSM=IDLE, bit_cnt=0,
//   baud_cnt=0, ovf=0, irq=1. Reset mid-frame aborts the frame and drops FIFO contents.
//  Decode: sel_data = baddr[31:2]==BASE[31:2]; sel_stat = baddr[31:2]==BASE[31:2]+1.
//  STATUS read: {28'b0, ovf, busy, empty, full}. bit0 full, bit1 FIFO empty,
//   bit2 busy (FSM!=IDLE), bit3 ovf sticky. DATA read returns 0.
//  DATA write (bwr & sel_data): push bdi[7:0] if !full. The full flag is sampled
//   before the edge. If full, the write is dropped and ovf<=1, even when a pop
//   happens in the same cycle.
//  STATUS write: bdi[3]=1 clears ovf. Other bits are ignored. Set and clear in the
//   same cycle cannot occur (distinct addresses).
//  FIFO: pointers are LOG_DEPTH+1 bits wide.
//   empty = ptrs equal. full = MSBs differ and the rest are equal.
//   Pointers wrap naturally. Push and pop in the same cycle are both legal.
//   There is no bypass: a byte pushed into an empty FIFO pops on the next edge
//   at the earliest.
//  FSM IDLE -> START -> DATA -> STOP -> (IDLE | START):
//   IDLE:  tx=1. If !empty: pop into shreg, baud_cnt=0, go START.
//   START: tx=0 for CLKS_PER_BIT cycles, then DATA with bit_cnt=0.
//   DATA:  tx=shreg[0] (LSB first) for CLKS_PER_BIT cycles each. Shift right
//          after each bit. After bit_cnt=7 go STOP.
//   STOP:  tx=1 for CLKS_PER_BIT cycles. At the end, if !empty, pop and go
//          straight to START (back-to-back, no idle gap); else go IDLE.
//  baud_cnt counts 0..CLKS_PER_BIT-1. The bit ends when it reaches CLKS_PER_BIT-1,
//   then it resets to 0.
//  tx is registered: it changes only on posedge, never glitches.
//  Latency: write to empty FIFO at edge N -> pop at edge N+1 -> tx falls after N+1.
//   Frame = 10*CLKS_PER_BIT cycles.
//  irq = empty & (state==IDLE), combinational from registers.
// TESTING
//  1 reset: rst_n=0 mid-frame -> tx=1 at once; STATUS=0x2; irq=1; no further edges on tx.
//  2 single byte: write 0x55 to 0x80000000 -> tx low 1 cycle after the edge.
//    Then 16 cycles 0, then bits 1,0,1,0,1,0,1,0 (16 each), then 16 cycles 1.
//    irq=1 after 160 cycles.
//  3 back-to-back: write 0x41,0x42 on consecutive cycles -> two frames,
//    STOP of 0x41 directly followed by START of 0x42 (no idle cycle).
//  4 overflow: 9 writes with FIFO empty, FSM IDLE -> first pops, 8 queued,
//    STATUS=0x5 (busy|full). 10th write -> STATUS=0xD, byte lost.
//    Write 0x8 to 0x80000004 -> ovf clears.
//  5 full+pop same cycle: write while full on the STOP->START pop edge -> write dropped,
//    ovf=1, FIFO count = DEPTH-1.
//  6 decode: write/read 0x80000008 and 0x00000000 -> no push; bdo=0 outside window;
//    bsz=word write of 0x12345678 to DATA sends 0x78.

Source files
------------

// File: rtl/uart_tx_mmio_if.sv
// Purpose: bus bundle between the core data port and the memory-mapped UART
//          transmitter. The core drives the write side; the UART answers with
//          combinational read data.
// Signals:
//   bdi   [31:0]  write data (only the low byte matters to the UART)
//   baddr [31:0]  byte address
//   bwr           write strobe, one access per cycle
//   bsz   [1:0]   access size (ignored by the UART)
//   bdo   [31:0]  read data, combinational
interface uart_tx_mmio_if;
  logic [31:0] bdi;
  logic [31:0] baddr;
  logic        bwr;
  logic [1:0]  bsz;
  logic [31:0] bdo;

  modport master (output bdi, output baddr, output bwr, output bsz, input bdo);
  modport slave  (input bdi, input baddr, input bwr, input bsz, output bdo);
endinterface

// File: rtl/uart_tx_mmio.sv
// Purpose: memory-mapped 8N1 UART transmitter. Byte writes to DATA are queued
//          in a small FIFO and shifted out LSB first on tx; STATUS reports
//          {ovf, busy, empty, full} and a write with bit 3 set clears ovf.
// Ports:
//   clk    clock, all state on posedge
//   rst_n  asynchronous active-low reset
//   bus    slave side of uart_tx_mmio_if (bdi, baddr, bwr, bsz in; bdo out)
//   tx     serial output, idle high, registered
//   irq    high while the FIFO is empty and the transmitter is idle
module uart_tx_mmio #(
  parameter logic [31:0] BASE         = 32'h80000000,
  parameter int          CLKS_PER_BIT = 16,
  parameter int          LOG_DEPTH    = 3
) (
  input  logic           clk,
  input  logic           rst_n,
  uart_tx_mmio_if.slave  bus,
  output logic           tx,
  output logic           irq
);

  localparam int DEPTH  = 1 << LOG_DEPTH;
  localparam int BAUD_W = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);
  localparam logic [29:0] WIN_DATA = BASE[31:2];
  localparam logic [29:0] WIN_STAT = BASE[31:2] + 30'd1;

  typedef enum logic [1:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_STOP
  } state_t;

  logic [7:0]          r_mem [DEPTH];
  logic [LOG_DEPTH:0]  r_wrPtr;
  logic [LOG_DEPTH:0]  r_rdPtr;
  logic                r_ovf;
  state_t              r_state;
  state_t              w_stateNext;
  logic [BAUD_W-1:0]   r_baudCnt;
  logic [BAUD_W-1:0]   w_baudNext;
  logic [2:0]          r_bitCnt;
  logic [2:0]          w_bitNext;
  logic [7:0]          r_shreg;
  logic [7:0]          w_shregNext;
  logic                r_tx;
  logic                w_txNext;
  logic                w_pop;
  logic                w_push;
  logic                w_empty;
  logic                w_full;
  logic                w_selData;
  logic                w_selStat;
  logic                w_bitEnd;
  logic [7:0]          w_head;
  logic                w_unused;

  assign w_selData = (bus.baddr[31:2] == WIN_DATA);
  assign w_selStat = (bus.baddr[31:2] == WIN_STAT);

  // Extra pointer bit distinguishes full from empty when the index bits match.
  assign w_empty = (r_wrPtr == r_rdPtr);
  assign w_full  = (r_wrPtr[LOG_DEPTH] != r_rdPtr[LOG_DEPTH]) &&
                   (r_wrPtr[LOG_DEPTH-1:0] == r_rdPtr[LOG_DEPTH-1:0]);
  assign w_head  = r_mem[r_rdPtr[LOG_DEPTH-1:0]];

  // Full is judged before the edge, so a write that meets a pop is still lost.
  assign w_push  = bus.bwr && w_selData && !w_full;

  assign w_bitEnd = (r_baudCnt == BAUD_LAST);

  assign bus.bdo = w_selStat ? {28'b0, r_ovf, (r_state != S_IDLE), w_empty, w_full}
                             : 32'b0;

  assign tx  = r_tx;
  assign irq = w_empty && (r_state == S_IDLE);

  assign w_unused = ^{bus.bsz, bus.bdi[31:8], bus.baddr[1:0]};

  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wrPtr[LOG_DEPTH-1:0]] <= bus.bdi[7:0];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wrPtr <= '0;
      r_rdPtr <= '0;
      r_ovf   <= 1'b0;
    end else begin
      if (w_push) begin
        r_wrPtr <= r_wrPtr + 1'b1;
      end
      if (w_pop) begin
        r_rdPtr <= r_rdPtr + 1'b1;
      end
      if (bus.bwr && w_selData && w_full) begin
        r_ovf <= 1'b1;
      end else if (bus.bwr && w_selStat && bus.bdi[3]) begin
        r_ovf <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= S_IDLE;
      r_baudCnt <= '0;
      r_bitCnt  <= '0;
      r_shreg   <= '0;
      r_tx      <= 1'b1;
    end else begin
      r_state   <= w_stateNext;
      r_baudCnt <= w_baudNext;
      r_bitCnt  <= w_bitNext;
      r_shreg   <= w_shregNext;
      r_tx      <= w_txNext;
    end
  end

  // w_txNext is the line level for the cycle after the edge, so tx stays a
  // clean register output and a pop drives the start bit on the same edge.
  always_comb begin
    w_stateNext = r_state;
    w_baudNext  = r_baudCnt;
    w_bitNext   = r_bitCnt;
    w_shregNext = r_shreg;
    w_txNext    = r_tx;
    w_pop       = 1'b0;
    case (r_state)
      S_IDLE: begin
        w_txNext = 1'b1;
        if (!w_empty) begin
          w_pop       = 1'b1;
          w_shregNext = w_head;
          w_baudNext  = '0;
          w_stateNext = S_START;
          w_txNext    = 1'b0;
        end
      end
      S_START: begin
        if (w_bitEnd) begin
          w_baudNext  = '0;
          w_bitNext   = '0;
          w_stateNext = S_DATA;
          w_txNext    = r_shreg[0];
        end else begin
          w_baudNext = r_baudCnt + 1'b1;
          w_txNext   = 1'b0;
        end
      end
      S_DATA: begin
        if (w_bitEnd) begin
          w_baudNext  = '0;
          w_shregNext = {1'b0, r_shreg[7:1]};
          if (r_bitCnt == 3'd7) begin
            w_stateNext = S_STOP;
            w_txNext    = 1'b1;
          end else begin
            w_bitNext = r_bitCnt + 1'b1;
            w_txNext  = r_shreg[1];
          end
        end else begin
          w_baudNext = r_baudCnt + 1'b1;
        end
      end
      S_STOP: begin
        if (w_bitEnd) begin
          w_baudNext = '0;
          if (!w_empty) begin
            w_pop       = 1'b1;
            w_shregNext = w_head;
            w_stateNext = S_START;
            w_txNext    = 1'b0;
          end else begin
            w_stateNext = S_IDLE;
            w_txNext    = 1'b1;
          end
        end else begin
          w_baudNext = r_baudCnt + 1'b1;
          w_txNext   = 1'b1;
        end
      end
      default: begin
        w_stateNext = S_IDLE;
        w_txNext    = 1'b1;
      end
    endcase
  end

endmodule
